// File: rtl/result_streamer_if.sv
// -----------------------------------------------------------------------------
// result_streamer_if
//
// Purpose:
//   Bundles the two bus-like port groups of the result streamer:
//   the result-buffer read port and the AXI-Stream style output.
//
// Signals:
//   rd_en    result buffer read strobe            (master -> slave)
//   rd_addr  result buffer read address           (master -> slave)
//   rd_data  buffer read data, one cycle after rd_en (slave -> master)
//   o_data   stream data                          (master -> slave)
//   o_valid  stream valid                         (master -> slave)
//   o_last   final beat of the matrix             (master -> slave)
//   o_ready  downstream ready                     (slave -> master)
//
// Modports:
//   master  the streamer side
//   slave   the buffer + downstream consumer side
// -----------------------------------------------------------------------------
interface result_streamer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              o_ready;
    logic              o_last;

    modport master (
        output rd_en,
        output rd_addr,
        input  rd_data,
        output o_data,
        output o_valid,
        output o_last,
        input  o_ready
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        output rd_data,
        input  o_data,
        input  o_valid,
        input  o_last,
        output o_ready
    );
endinterface

// File: rtl/result_streamer.sv
// -----------------------------------------------------------------------------
// result_streamer
//
// Purpose:
//   Reads a complete MATSIZE x MATSIZE result matrix from the result buffer
//   and streams it out as valid/ready/last beats, in row-major or
//   column-major order. Pulses o_intr for one cycle after the final beat is
//   accepted.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   start      one-cycle request to stream the matrix (ignored while busy)
//   col_major  order select, captured with an accepted start
//   busy       high from start acceptance through the final handshake
//   o_intr     one-cycle completion pulse
//   bus        result_streamer_if.master: buffer read port + output stream
//
// Structure:
//   A 3-state FSM (IDLE/RUN/DRAIN) issues reads; read data lands one cycle
//   later in a 2-entry FIFO whose head drives the stream. A credit check
//   (FIFO occupancy + in-flight read - pop < 2) gates every read, so the FIFO
//   cannot overflow yet still sustains one beat per cycle under o_ready=1.
// -----------------------------------------------------------------------------
module result_streamer #(
    parameter int MATSIZE = 16,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = $clog2(MATSIZE * MATSIZE)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                col_major,
    output logic                busy,
    output logic                o_intr,
    result_streamer_if.master   bus
);

    localparam int NWORDS = MATSIZE * MATSIZE;
    localparam int CNT_W  = $clog2(NWORDS) + 1;
    localparam int LOG_M  = $clog2(MATSIZE);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t             r_state;
    logic               r_col_major;
    logic [CNT_W-1:0]   r_rd_cnt;      // reads issued in this matrix
    logic [CNT_W-1:0]   r_tx_cnt;      // beats handshaken in this matrix
    logic               r_inflight;    // a read was issued last cycle
    logic [DATA_W-1:0]  r_fifo [2];
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [1:0]         r_count;       // FIFO occupancy, 0..2
    logic               r_intr;

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_rd_en;
    logic               w_credit_ok;
    logic               w_push;
    logic               w_pop;
    logic               w_valid;
    logic               w_last;
    logic               w_last_hs;
    logic [ADDR_W-1:0]  w_rd_addr;
    logic [LOG_M-1:0]   w_cnt_lo;      // rd_cnt % MATSIZE
    logic [LOG_M-1:0]   w_cnt_hi;      // rd_cnt / MATSIZE
    logic [2:0]         w_credit_sum;

    // -------------------------------------------------------------------------
    // Stream side
    // -------------------------------------------------------------------------
    assign w_valid   = (r_count != 2'd0);
    assign w_pop     = w_valid & bus.o_ready;
    assign w_last    = w_valid & (r_tx_cnt == LAST_IDX);
    assign w_last_hs = w_pop & w_last;

    // The in-flight read of the previous cycle is the only source of data.
    assign w_push    = r_inflight;

    assign bus.o_data  = r_fifo[r_rd_ptr];
    assign bus.o_valid = w_valid;
    assign bus.o_last  = w_last;

    // -------------------------------------------------------------------------
    // Read issue: credit check counts words already buffered plus the one
    // still in flight, minus the word leaving this cycle. Never negative,
    // since a pop needs r_count >= 1.
    // -------------------------------------------------------------------------
    assign w_credit_sum = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_credit_ok  = (w_credit_sum < 3'd2);
    assign w_rd_en      = (r_state == RUN) & w_credit_ok;

    // MATSIZE is a power of two: % and / are plain bit slices of the counter,
    // so the column-major address is simply the two halves swapped.
    assign w_cnt_lo  = r_rd_cnt[LOG_M-1:0];
    assign w_cnt_hi  = r_rd_cnt[2*LOG_M-1:LOG_M];
    assign w_rd_addr = r_col_major ? {w_cnt_lo, w_cnt_hi} : r_rd_cnt[ADDR_W-1:0];

    assign bus.rd_en   = w_rd_en;
    assign bus.rd_addr = w_rd_addr;

    assign busy   = (r_state != IDLE);
    assign o_intr = r_intr;

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_rd_en && (r_rd_cnt == LAST_IDX)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_last_hs) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: state register, counters, completion pulse
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state     <= IDLE;
            r_col_major <= 1'b0;
            r_rd_cnt    <= '0;
            r_tx_cnt    <= '0;
            r_inflight  <= 1'b0;
            r_intr      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_rd_en;
            r_intr     <= w_last_hs;
            // Accept happens only in IDLE, where neither reads nor pops occur.
            if (w_accept) begin
                r_col_major <= col_major;
                r_rd_cnt    <= '0;
                r_tx_cnt    <= '0;
            end else begin
                if (w_rd_en) begin
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                end
                if (w_pop) begin
                    r_tx_cnt <= r_tx_cnt + 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // 2-entry FIFO
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: the storage is only two words and drives o_data directly, so
        // it is reset to keep o_data at 0 out of reset; a real RAM would not be.
        if (rst) begin
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= bus.rd_data;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_result_streamer.sv
// -----------------------------------------------------------------------------
// tb_result_streamer
//
// Purpose:
//   Self-checking bench for result_streamer with MATSIZE=4. A behavioural
//   result buffer holds buffer[i]=i. Each accepted start pushes the 16
//   expected words onto a scoreboard queue; a negedge monitor pops and
//   compares on every handshake, and also checks hold-during-stall, the
//   outstanding-word limit and the completion pulse.
// -----------------------------------------------------------------------------
module tb_result_streamer;

    localparam int MATSIZE = 4;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 4;
    localparam int NWORDS  = MATSIZE * MATSIZE;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic col_major = 1'b0;
    logic busy;
    logic o_intr;

    result_streamer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    result_streamer #(
        .MATSIZE (MATSIZE),
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .col_major (col_major),
        .busy      (busy),
        .o_intr    (o_intr),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Result buffer model: one-cycle read latency.
    logic [DATA_W-1:0] mem [NWORDS];
    initial begin
        for (int i = 0; i < NWORDS; i++) mem[i] = DATA_W'(i);
        bus.rd_data = '0;
        bus.o_ready = 1'b1;
    end
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Edge counter: at a negedge, cyc is the index of the last rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // -------------------------------------------------------------------------
    // Scoreboard + monitor
    // -------------------------------------------------------------------------
    beat_t             exp_q[$];
    int                beats = 0;
    int                intr_cnt = 0;
    int                rd_en_cnt = 0;
    int                outstanding = 0;
    int                last_hs_edge = 0;
    logic              exp_intr = 1'b0;
    logic              stall_v = 1'b0;
    logic [DATA_W-1:0] stall_d = '0;
    logic              stall_l = 1'b0;

    always @(negedge clk) begin
        logic  hs;
        beat_t b;
        if (rst) begin
            exp_q.delete();
            outstanding = 0;
            exp_intr    = 1'b0;
            stall_v     = 1'b0;
        end else begin
            if (o_intr || exp_intr) check("intr", o_intr, exp_intr);
            if (o_intr) intr_cnt++;
            exp_intr = 1'b0;

            if (stall_v) begin
                check("hold_valid", bus.o_valid, 1'b1);
                check("hold_data", bus.o_data, stall_d);
                check("hold_last", bus.o_last, stall_l);
            end

            hs = bus.o_valid && bus.o_ready;
            if (bus.rd_en) begin
                rd_en_cnt++;
                check("outstanding_le_2", (outstanding + 1 - int'(hs)) <= 2, 1'b1);
            end
            if (hs) begin
                check("beat_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    b = exp_q.pop_front();
                    check("data", bus.o_data, b.data);
                    check("last", bus.o_last, b.last);
                    exp_intr = b.last;
                end
                beats++;
                last_hs_edge = cyc + 1;
            end
            outstanding = outstanding + int'(bus.rd_en) - int'(hs);

            stall_v = bus.o_valid && !bus.o_ready;
            stall_d = bus.o_data;
            stall_l = bus.o_last;
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers (all called at posedge + 1)
    // -------------------------------------------------------------------------
    int e0 = 0;

    task automatic do_start(input logic cm);
        beat_t b;
        int    a;
        start     = 1'b1;
        col_major = cm;
        if (!busy) begin
            for (int k = 0; k < NWORDS; k++) begin
                a      = cm ? ((k % MATSIZE) * MATSIZE + k / MATSIZE) : k;
                b.data = mem[a];
                b.last = (k == NWORDS - 1);
                exp_q.push_back(b);
            end
        end
        beats    = 0;
        intr_cnt = 0;
        @(posedge clk); #1;
        e0    = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input logic rnd);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            if (rnd) bus.o_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        check("done_in_time", n < budget, 1'b1);
        bus.o_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("beat_count", beats, NWORDS);
        check("intr_pulses", intr_cnt, 1);
        check("busy_idle", busy, 1'b0);
    endtask

    // -------------------------------------------------------------------------
    // Test sequence
    // -------------------------------------------------------------------------
    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", bus.o_valid, 1'b0);
        check("rst_last", bus.o_last, 1'b0);
        check("rst_intr", o_intr, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rd_en", bus.rd_en, 1'b0);
        check("rst_rd_addr", bus.rd_addr, 0);
        check("rst_data", bus.o_data, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: row-major, full rate, latency
        bus.o_ready = 1'b1;
        do_start(1'b0);
        @(negedge clk);
        check("lat_busy", busy, 1'b1);
        check("lat_rd_en", bus.rd_en, 1'b1);
        check("lat_rd_addr", bus.rd_addr, 0);
        check("lat_valid_e0", bus.o_valid, 1'b0);
        @(negedge clk);
        check("lat_valid_e1", bus.o_valid, 1'b0);
        @(negedge clk);
        check("lat_valid_e2", bus.o_valid, 1'b1);
        @(posedge clk); #1;
        wait_done(200, 1'b0);
        check("row_last_edge", last_hs_edge - e0, NWORDS + 2);

        // 2: column-major, full rate
        do_start(1'b1);
        wait_done(200, 1'b0);
        check("col_last_edge", last_hs_edge - e0, NWORDS + 2);

        // 3: random backpressure
        do_start(1'b0);
        wait_done(2000, 1'b1);

        // 4: start held while busy, including the final handshake cycle
        do_start(1'b0);
        n = 0;
        while (busy && n < 200) begin
            start = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check("spam_bounded", n < 200, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("spam_busy", busy, 1'b0);
        check("spam_beats", beats, NWORDS);
        check("spam_q_empty", exp_q.size(), 0);
        do_start(1'b0);
        wait_done(200, 1'b0);

        // 5: reset after beat 5 handshake
        do_start(1'b0);
        n = 0;
        while (beats < 6 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_beat5", beats, 6);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", bus.o_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_intr", o_intr, 1'b0);
        check("mid_rst_rd_en", bus.rd_en, 1'b0);
        @(posedge clk); #1;
        do_start(1'b0);
        wait_done(200, 1'b0);

        // 6: o_ready low for 20 cycles from start
        bus.o_ready = 1'b0;
        rd_en_cnt   = 0;
        do_start(1'b0);
        repeat (19) @(posedge clk);
        #1;
        check("stall_rd_en_cnt", rd_en_cnt, 2);
        check("stall_valid", bus.o_valid, 1'b1);
        check("stall_word0", bus.o_data, 0);
        check("stall_no_beats", beats, 0);
        bus.o_ready = 1'b1;
        wait_done(200, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/result_streamer.md
# result_streamer

Output-side transmitter for the matrix-multiplication accelerator. Once the compute array has written a complete MATSIZE×MATSIZE result matrix into the result buffer, this block reads it and streams it out as AXI-Stream master beats (valid/ready/last). It raises a one-cycle interrupt when the final beat is accepted. It is the counterpart of the input controller, which accepts matrix B over an AXI slave handshake and writes it transposed into the cache buffer.

## Interface
- MATSIZE, 16, matrix dimension; the block streams MATSIZE*MATSIZE words.
- DATA_W, 32, result word width.
- ADDR_W, $clog2(MATSIZE*MATSIZE), result buffer address width.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to stream the current result matrix; ignored while busy=1.
- col_major  in  1  order select, sampled only with an accepted start: 0 = row-major, 1 = column-major.
- rd_en  out  1  result buffer read strobe.
- rd_addr  out  ADDR_W  result buffer read address.
- rd_data  in  DATA_W  buffer read data, valid exactly 1 cycle after rd_en.
- o_data  out  DATA_W  stream data.
- o_valid  out  1  stream valid.
- o_ready  in  1  downstream ready.
- o_last  out  1  high on the final beat of the matrix.
- busy  out  1  high from start acceptance through the final handshake.
- o_intr  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 latches col_major.
  - Clears the issue counter (rd_cnt) and the beat counter (tx_cnt).
  - Moves to RUN.
- RUN:
  - Issues reads of rd_cnt = 0 … MATSIZE²−1 in order.
  - Moves to DRAIN after the read with rd_cnt = MATSIZE²−1 is issued.
- DRAIN:
  - No further reads.
  - Returns to IDLE on the handshake with o_last=1.
- Address mapping:
  - col_major=0: rd_addr = rd_cnt.
  - col_major=1: rd_addr = (rd_cnt % MATSIZE)*MATSIZE + rd_cnt / MATSIZE.
  - MATSIZE is a power of two, so % and / are bit slices.
- Read data lands in a 2-entry FIFO. The FIFO head drives o_data; o_valid = (FIFO not empty).
- Credit rule: rd_en = 1 only in RUN and when (fifo_count + inflight − pop) < 2, where pop = o_valid & o_ready.
  - The FIFO never overflows.
  - With o_ready held high, the stream runs at 1 beat/cycle.
- A handshake (o_valid & o_ready) pops the FIFO and increments tx_cnt.
- o_last = o_valid & (tx_cnt == MATSIZE²−1).
- On the last handshake:
  - o_intr=1 for exactly the next cycle.
  - busy falls.
  - State returns to IDLE.
- A start that coincides with the last handshake is ignored (busy still 1 in that cycle).
- o_data and o_last hold stable while o_valid=1 and o_ready=0.
- o_valid never drops without a handshake.
- Counters are $clog2(MATSIZE²)+1 bits wide. No wrap-around occurs within a matrix.

## Timing
- Reset values:
  - o_valid=0, o_last=0, o_intr=0, busy=0, rd_en=0, rd_addr=0, o_data=0.
  - FIFO empty, inflight=0, state IDLE.
- Reset mid-operation:
  - All state is cleared on the reset edge.
  - An in-flight read is discarded.
  - o_valid falls on the reset edge with no handshake.
  - o_intr is not pulsed.
- Latency:
  - start sampled at edge E0.
  - busy=1 and rd_en=1 (addr 0) after E0.
  - rd_data captured into the FIFO at E2.
  - o_valid=1 after E2.
- Full-rate matrix with o_ready=1: MATSIZE² consecutive beats, last beat handshaken at edge E(MATSIZE²+2), o_intr high the following cycle.
- Backpressure with o_ready=0: at most 2 words buffered; rd_en stays 0 once fifo_count + inflight = 2.
- o_ready asserted without o_valid has no effect.

## Test plan
- MATSIZE=4, buffer[i]=i, col_major=0, o_ready=1:
  - Beats are 0,1,…,15 on consecutive cycles.
  - o_last only on 15.
  - First o_valid 3 cycles after start; o_intr a single pulse.
- Same setup with col_major=1:
  - Beats are 0,4,8,12,1,5,9,13,…,3,7,11,15.
  - o_last on 15.
- Random o_ready (50%), col_major=0:
  - Exactly 16 beats in order 0..15, no duplicates or drops.
  - o_data stable during stalls.
  - Each rd_en has at most 2 unconsumed words outstanding.
- start re-asserted at every cycle while busy, including the cycle of the final handshake:
  - Exactly one 16-beat matrix.
  - A fresh start after busy=0 produces a second 16-beat matrix.
- rst pulsed after beat 5 handshake:
  - o_valid=0, busy=0, o_intr=0 next cycle.
  - A subsequent start streams 0..15 from address 0.
- o_ready=0 from start for 20 cycles, then 1:
  - rd_en pulses exactly twice during the stall.
  - Word 0 held on o_data.
  - All 16 beats then arrive in order.
